// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares the single L2 request port between the L1 I-cache
// and L1 D-cache controllers. One transaction is outstanding at a time.
// A granted request is latched and presented to L2 on the next cycle.
// L2's ready pulse is routed combinationally back to the owning side only.
// Each completion is followed by one RELEASE cycle, so the finished requester
// can drop its level request before the next arbitration.
// Optional build macro ARB_FIXED_PRIO_EN: when defined, the D-side always
// wins ties. When undefined (default), ties alternate round-robin.
module l1_l2_arbiter #(
    parameter int TNUM = 21,
    parameter int INUM = 26 - TNUM
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            read_I_ARB,
    input  logic [TNUM-1:0] tag_I_ARB,
    input  logic [INUM-1:0] index_I_ARB,
    output logic            ready_ARB_I,
    input  logic            read_D_ARB,
    input  logic            write_D_ARB,
    input  logic [TNUM-1:0] tag_D_ARB,
    input  logic [INUM-1:0] index_D_ARB,
    output logic            ready_ARB_D,
    output logic            read_ARB_L2,
    output logic            write_ARB_L2,
    output logic [TNUM-1:0] tag_ARB_L2,
    output logic [INUM-1:0] index_ARB_L2,
    input  logic            ready_L2_ARB,
    output logic            owner,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state_r;
    logic   last_grant_r;   // 0 = I-side was granted last, 1 = D-side
    logic   req_i_s;
    logic   req_d_s;
    logic   grant_s;
    logic   pick_d_s;

    // Decode pending requests and choose the winner for an IDLE-cycle grant
    always_comb begin
        req_i_s = read_I_ARB;
        req_d_s = read_D_ARB | write_D_ARB;
        grant_s = req_i_s | req_d_s;
        if (req_i_s && req_d_s) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_d_s = 1'b1;
`else
            pick_d_s = ~last_grant_r;
`endif
        end else begin
            pick_d_s = req_d_s;
        end
    end

    // Route L2 completion to the current owner only, and only while a transaction is outstanding
    always_comb begin
        ready_ARB_I = 1'b0;
        ready_ARB_D = 1'b0;
        if (state_r == BUSY_I) begin
            ready_ARB_I = ready_L2_ARB;
        end else if (state_r == BUSY_D) begin
            ready_ARB_D = ready_L2_ARB;
        end else begin
            ready_ARB_I = 1'b0;
            ready_ARB_D = 1'b0;
        end
    end

    // Arbitration FSM with registered L2 command, address, owner and busy outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            read_ARB_L2  <= 1'b0;
            write_ARB_L2 <= 1'b0;
            tag_ARB_L2   <= {TNUM{1'b0}};
            index_ARB_L2 <= {INUM{1'b0}};
            owner        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r      <= pick_d_s ? BUSY_D : BUSY_I;
                        last_grant_r <= pick_d_s;
                        owner        <= pick_d_s;
                        busy         <= 1'b1;
                        if (pick_d_s) begin
                            // A pending write-back goes first; a held read re-arbitrates later
                            tag_ARB_L2   <= tag_D_ARB;
                            index_ARB_L2 <= index_D_ARB;
                            write_ARB_L2 <= write_D_ARB;
                            read_ARB_L2  <= ~write_D_ARB;
                        end else begin
                            tag_ARB_L2   <= tag_I_ARB;
                            index_ARB_L2 <= index_I_ARB;
                            write_ARB_L2 <= 1'b0;
                            read_ARB_L2  <= 1'b1;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // L2 cannot abort, so only its ready ends the transaction
                    if (ready_L2_ARB) begin
                        state_r      <= RELEASE;
                        read_ARB_L2  <= 1'b0;
                        write_ARB_L2 <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    read_ARB_L2  <= 1'b0;
                    write_ARB_L2 <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Testbench for l1_l2_arbiter: directed scenarios followed by random traffic.
// A reference model predicts each grant and pushes it into a scoreboard queue.
// A negedge monitor pops an entry whenever the DUT raises busy and compares
// the presented transaction against it.
module tb_l1_l2_arbiter;

    localparam int TNUM = 21;
    localparam int INUM = 26 - TNUM;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            nrst;
    logic            read_I_ARB, read_D_ARB, write_D_ARB, ready_L2_ARB;
    logic [TNUM-1:0] tag_I_ARB, tag_D_ARB;
    logic [INUM-1:0] index_I_ARB, index_D_ARB;
    logic            ready_ARB_I, ready_ARB_D, read_ARB_L2, write_ARB_L2, owner, busy;
    logic [TNUM-1:0] tag_ARB_L2;
    logic [INUM-1:0] index_ARB_L2;

    l1_l2_arbiter #(.TNUM(TNUM)) dut (
        .clk(clk), .nrst(nrst),
        .read_I_ARB(read_I_ARB), .tag_I_ARB(tag_I_ARB), .index_I_ARB(index_I_ARB),
        .ready_ARB_I(ready_ARB_I),
        .read_D_ARB(read_D_ARB), .write_D_ARB(write_D_ARB),
        .tag_D_ARB(tag_D_ARB), .index_D_ARB(index_D_ARB), .ready_ARB_D(ready_ARB_D),
        .read_ARB_L2(read_ARB_L2), .write_ARB_L2(write_ARB_L2),
        .tag_ARB_L2(tag_ARB_L2), .index_ARB_L2(index_ARB_L2),
        .ready_L2_ARB(ready_L2_ARB), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic            own;
        logic            wr;
        logic            rd;
        logic [TNUM-1:0] tag;
        logic [INUM-1:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] log_q[$];     // {owner, write, read} per observed transaction
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulses_i = 0;
    int pulses_d = 0;

    // reference model state
    logic m_busy, m_rel, m_last, m_own, w_m;
    exp_t e_m;

    // monitor state / values sampled for the stimulus driver
    exp_t cur;
    logic have_cur = 1'b0;
    logic busy_seen = 1'b0, ri_seen = 1'b0, rd_seen = 1'b0;

    // stimulus control
    logic rand_en = 1'b0;
    int   fixed_lat = -1;
    int   l2_wait = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, one dead cycle after each,
    // ties resolved against the side served last (or always D with fixed priority)
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy <= 1'b0;
            m_rel  <= 1'b0;
            m_last <= 1'b1;
            m_own  <= 1'b0;
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (m_busy) begin
                if (ready_L2_ARB) begin
                    m_busy <= 1'b0;
                    m_rel  <= 1'b1;
                end
            end else if (m_rel) begin
                m_rel <= 1'b0;
            end else if (read_I_ARB || read_D_ARB || write_D_ARB) begin
                if (read_I_ARB && (read_D_ARB || write_D_ARB))
                    w_m = FIXED_PRIO ? 1'b1 : !m_last;
                else
                    w_m = !read_I_ARB;
                e_m.cyc = cyc + 1;
                e_m.own = w_m;
                e_m.wr  = w_m && write_D_ARB;
                e_m.rd  = !e_m.wr;
                e_m.tag = w_m ? tag_D_ARB : tag_I_ARB;
                e_m.idx = w_m ? index_D_ARB : index_I_ARB;
                exp_q.push_back(e_m);
                m_busy <= 1'b1;
                m_own  <= w_m;
                m_last <= w_m;
            end
        end
    end

    // Monitor: compare ready routing every cycle; pop and check a transaction when busy rises
    always @(negedge clk) begin
        if (!nrst) begin
            have_cur  = 1'b0;
            busy_seen = 1'b0;
            ri_seen   = 1'b0;
            rd_seen   = 1'b0;
        end else begin
            chk("ready_I", 32'(ready_ARB_I), 32'(m_busy && !m_own && ready_L2_ARB));
            chk("ready_D", 32'(ready_ARB_D), 32'(m_busy && m_own && ready_L2_ARB));
            chk("busy", 32'(busy), 32'(m_busy));
            if (ready_ARB_I) pulses_i++;
            if (ready_ARB_D) pulses_d++;
            if (busy && !have_cur) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(1), 32'(0));
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("latency", 32'(cyc), 32'(cur.cyc));
                    log_q.push_back({cur.own, cur.wr, cur.rd});
                end
            end
            if (busy && have_cur) begin
                chk("owner", 32'(owner), 32'(cur.own));
                chk("read_L2", 32'(read_ARB_L2), 32'(cur.rd));
                chk("write_L2", 32'(write_ARB_L2), 32'(cur.wr));
                chk("tag_L2", 32'(tag_ARB_L2), 32'(cur.tag));
                chk("index_L2", 32'(index_ARB_L2), 32'(cur.idx));
            end
            if (!busy) begin
                have_cur = 1'b0;
                chk("idle_cmd", 32'({read_ARB_L2, write_ARB_L2}), 32'(0));
            end
            busy_seen = busy;
            ri_seen   = ready_ARB_I;
            rd_seen   = ready_ARB_D;
        end
    end

    // One cycle of stimulus, called just after each rising edge
    task automatic drive_cycle();
        // L2 responder
        if (busy_seen && !ready_L2_ARB) begin
            if (l2_wait == 0) ready_L2_ARB = 1'b1;
            else l2_wait--;
        end else begin
            ready_L2_ARB = (!busy_seen && rand_en && $urandom_range(0, 7) == 0);
            l2_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        end
        // requesters drop their level once served
        if (ri_seen) read_I_ARB = 1'b0;
        if (rd_seen) begin
            if (write_D_ARB) write_D_ARB = 1'b0;
            else read_D_ARB = 1'b0;
        end
        if (rand_en) begin
            if (!read_I_ARB && $urandom_range(0, 3) == 0) begin
                read_I_ARB  = 1'b1;
                tag_I_ARB   = TNUM'($urandom);
                index_I_ARB = INUM'($urandom);
            end else if (read_I_ARB && $urandom_range(0, 15) == 0) begin
                read_I_ARB = 1'b0;
            end
            if (!read_D_ARB && !write_D_ARB && $urandom_range(0, 3) == 0) begin
                w_dummy = 2'($urandom_range(1, 3));
                write_D_ARB = w_dummy[1];
                read_D_ARB  = w_dummy[0];
                tag_D_ARB   = TNUM'($urandom);
                index_D_ARB = INUM'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                tag_I_ARB   = TNUM'($urandom);
                index_I_ARB = INUM'($urandom);
            end
            if ($urandom_range(0, 5) == 0) tag_D_ARB = TNUM'($urandom);
        end
    endtask
    logic [1:0] w_dummy;

    task automatic run(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    endtask

    task automatic wait_busy(string nm);
        int t = 0;
        while (!busy_seen && t < 20) begin
            run(1);
            t++;
        end
        chk(nm, 32'(busy_seen), 32'(1));
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        read_I_ARB = 1'b0; read_D_ARB = 1'b0; write_D_ARB = 1'b0; ready_L2_ARB = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        nrst = 1'b1;
        log_q.delete();
    endtask

    task automatic check_log(string nm, int n, logic [11:0] ex);
        chk({nm, "_count"}, 32'(log_q.size()), 32'(n));
        for (int k = 0; k < n && k < log_q.size(); k++)
            chk(nm, 32'(log_q[k]), 32'(ex[3*k +: 3]));
        log_q.delete();
    endtask

    task automatic check_outputs_zero(string nm);
        chk({nm, "_read"}, 32'(read_ARB_L2), 32'(0));
        chk({nm, "_write"}, 32'(write_ARB_L2), 32'(0));
        chk({nm, "_busy"}, 32'(busy), 32'(0));
        chk({nm, "_owner"}, 32'(owner), 32'(0));
        chk({nm, "_rdyI"}, 32'(ready_ARB_I), 32'(0));
        chk({nm, "_rdyD"}, 32'(ready_ARB_D), 32'(0));
        chk({nm, "_tag"}, 32'(tag_ARB_L2), 32'(0));
        chk({nm, "_index"}, 32'(index_ARB_L2), 32'(0));
    endtask

    initial begin
        int p0;
        logic [11:0] ex;
        nrst = 1'b0;
        read_I_ARB = 1'b0; read_D_ARB = 1'b0; write_D_ARB = 1'b0; ready_L2_ARB = 1'b1;
        tag_I_ARB = '0; index_I_ARB = '0; tag_D_ARB = '0; index_D_ARB = '0;
        #3;
        check_outputs_zero("reset");
        do_reset();

        // 1: I-only read with a 4-cycle L2 response
        fixed_lat = 3;
        p0 = pulses_i;
        run(1);
        read_I_ARB = 1'b1; tag_I_ARB = 21'h1ABCD; index_I_ARB = 5'h05;
        run(12);
        chk("t1_pulse_I", 32'(pulses_i - p0), 32'(1));
        check_log("t1_log", 1, 12'h001);

        // 2: ties after reset, repeated
        do_reset();
        fixed_lat = 1;
        run(1);
        read_I_ARB = 1'b1; tag_I_ARB = 21'h00111; index_I_ARB = 5'h01;
        read_D_ARB = 1'b1; tag_D_ARB = 21'h00222; index_D_ARB = 5'h02;
        run(20);
        read_I_ARB = 1'b1; read_D_ARB = 1'b1;
        run(20);
        ex = FIXED_PRIO ? {3'b001, 3'b101, 3'b001, 3'b101} : {3'b101, 3'b001, 3'b101, 3'b001};
        check_log("t2_order", 4, ex);

        // 3: D write-back plus refill: write first, then read at the same index
        write_D_ARB = 1'b1; read_D_ARB = 1'b1; tag_D_ARB = 21'h0BEEF; index_D_ARB = 5'h0A;
        run(20);
        check_log("t3_wb_then_rd", 2, {6'd0, 3'b101, 3'b110});

        // 4: input churn and withdrawal while the I-side owns L2
        fixed_lat = 3;
        p0 = pulses_i;
        read_I_ARB = 1'b1; tag_I_ARB = 21'h12345; index_I_ARB = 5'h11;
        wait_busy("t4_grant");
        tag_I_ARB = 21'h1FFFF; index_I_ARB = 5'h1E; read_I_ARB = 1'b0;
        run(10);
        chk("t4_pulse_I", 32'(pulses_i - p0), 32'(1));
        check_log("t4_log", 1, 12'h001);

        // 5: spurious L2 ready while idle
        run(3);
        p0 = pulses_i + pulses_d;
        ready_L2_ARB = 1'b1;
        run(3);
        chk("t5_no_pulse", 32'(pulses_i + pulses_d - p0), 32'(0));
        chk("t5_idle", 32'(busy), 32'(0));

        // 6: reset while the D-side owns L2, then a tie
        write_D_ARB = 1'b1; tag_D_ARB = 21'h0CAFE; index_D_ARB = 5'h07;
        wait_busy("t6_grant");
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        write_D_ARB = 1'b0; read_D_ARB = 1'b0; ready_L2_ARB = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        nrst = 1'b1;
        log_q.delete();
        run(1);
        read_I_ARB = 1'b1; read_D_ARB = 1'b1;
        run(20);
        ex = FIXED_PRIO ? {6'd0, 3'b001, 3'b101} : {6'd0, 3'b101, 3'b001};
        check_log("t6_after_reset", 2, ex);

        // random traffic, then drain
        fixed_lat = -1;
        rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        run(80);
        chk("drain", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
